// File: rtl/msrv32_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | msrv32_instr_encoder: two-stage RV32I field-to-word encoder with a        |
// | word-address stream for instruction-memory loading.   Revision: 1.0      |
// +--------------------------------------------------------------------------+
module msrv32_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_n_in,
  input  logic              flush_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [2:0]        format_in,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [6:0]        funct7_in,
  input  logic [4:0]        rs1addr_in,
  input  logic [4:0]        rs2addr_in,
  input  logic [4:0]        rdaddr_in,
  input  logic [31:0]       imm_in,
  output logic [31:0]       instr_out,
  output logic              illegal_out,
  output logic              instr_valid_out,
  input  logic              instr_ready_in,
  output logic [ADDR_W-1:0] imem_addr_out
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic              s1_valid_q;
  logic [2:0]        fmt_q;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [6:0]        f7_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [4:0]        rd_q;
  logic [31:0]       imm_q;

  logic              s2_valid_q;
  logic [31:0]       word_q;
  logic              illegal_q;
  logic [ADDR_W-1:0] addr_q;

  logic [31:0]       word_d;
  logic              illegal_d;
  logic              s2_free;
  logic              accept;
  logic              xfer;
  logic              out_hs;

  assign s2_free         = !s2_valid_q || instr_ready_in;
  assign ready_out       = !flush_in && (!s1_valid_q || s2_free);
  assign accept          = valid_in && ready_out;
  assign xfer            = s1_valid_q && s2_free;
  assign out_hs          = s2_valid_q && instr_ready_in;

  assign instr_out       = word_q;
  assign illegal_out     = illegal_q;
  assign instr_valid_out = s2_valid_q;
  assign imem_addr_out   = addr_q;

  always_comb begin
    word_d    = NOP;
    illegal_d = 1'b0;
    case (fmt_q)
      FMT_R: word_d = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      FMT_I: word_d = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
      FMT_S: word_d = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
      FMT_B: word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                       imm_q[4:1], imm_q[11], op_q};
      FMT_U: word_d = {imm_q[31:12], rd_q, op_q};
      FMT_J: word_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                       rd_q, op_q};
      default: begin
        word_d    = NOP;
        illegal_d = 1'b1;
      end
    endcase
    // Branch/jump targets must be halfword aligned; bit 0 is not encodable.
    if ((fmt_q == FMT_B || fmt_q == FMT_J) && imm_q[0]) illegal_d = 1'b1;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      s1_valid_q <= 1'b0;
      fmt_q      <= '0;
      op_q       <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      s2_valid_q <= 1'b0;
      word_q     <= '0;
      illegal_q  <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
    end else begin
      if (out_hs) addr_q <= addr_q + ADDR_W'(1);

      if (accept) begin
        fmt_q <= format_in;
        op_q  <= opcode_in;
        f3_q  <= funct3_in;
        f7_q  <= funct7_in;
        rs1_q <= rs1addr_in;
        rs2_q <= rs2addr_in;
        rd_q  <= rdaddr_in;
        imm_q <= imm_in;
      end

      if (xfer) begin
        word_q    <= word_d;
        illegal_q <= illegal_d;
      end

      if (flush_in) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (accept)      s1_valid_q <= 1'b1;
        else if (xfer)   s1_valid_q <= 1'b0;
        if (xfer)        s2_valid_q <= 1'b1;
        else if (out_hs) s2_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
